// File: rtl/floo_mcast_output_arbiter.sv
// ----------------------------------------------------------------------------
// floo_mcast_output_arbiter
//
// Per-output wormhole arbiter with multicast fork for the ring-on-mesh router.
// Each output picks one requesting input. When the output is unlocked, the
// choice is round-robin. When the output is locked, the choice is the input
// that owns the current packet. A multicast flit is forked to every output in
// its route mask. The input is released only after all of those outputs have
// taken the flit. Outputs are purely combinational (zero latency).
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        per-input flit valid
//   ready_o        per-input release: every selected output has the flit
//   data_i         per-input flit payload
//   route_sel_i    per-input multi-hot destination mask (one bit per output)
//   last_i         per-input last-flit-of-packet marker
//   valid_o        per-output flit valid (independent of ready_i)
//   ready_i        per-output downstream ready
//   data_o         per-output flit payload (zero when valid_o is low)
//   grant_idx_o    per-output winning input index (zero when valid_o is low)
// ----------------------------------------------------------------------------
module floo_mcast_output_arbiter #(
    parameter int unsigned NumInputs   = 5,
    parameter int unsigned NumRoutes   = 5,
    parameter type         flit_t      = logic,
    parameter bit          LockRouting = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumInputs-1:0]         valid_i,
    output logic [NumInputs-1:0]         ready_o,
    input  flit_t                        data_i      [NumInputs],
    input  logic [NumRoutes-1:0]         route_sel_i [NumInputs],
    input  logic [NumInputs-1:0]         last_i,
    output logic [NumRoutes-1:0]         valid_o,
    input  logic [NumRoutes-1:0]         ready_i,
    output flit_t                        data_o      [NumRoutes],
    output logic [$clog2(NumInputs)-1:0] grant_idx_o [NumRoutes]
);

    localparam int unsigned IdxW = $clog2(NumInputs);
    typedef logic [IdxW-1:0] idx_t;

    // (base + k) mod NumInputs, for base < NumInputs and k <= NumInputs
    function automatic idx_t wrap_add(idx_t base, int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NumInputs) s = s - NumInputs;
        return idx_t'(s);
    endfunction

    // State
    logic [NumRoutes-1:0] r_sent     [NumInputs];  // outputs that already took the current flit
    logic [NumRoutes-1:0] r_lock;
    idx_t                 r_lock_idx [NumRoutes];
    idx_t                 r_rr_ptr   [NumRoutes];

    // Combinational
    logic [NumInputs-1:0] w_req       [NumRoutes];
    logic [NumRoutes-1:0] w_valid;
    idx_t                 w_winner    [NumRoutes];
    logic [NumRoutes-1:0] w_xfer;
    logic [NumRoutes-1:0] w_xfer_from [NumInputs];
    logic [NumInputs-1:0] w_done;

    // Request matrix: an input stops requesting an output once that output has the flit
    always_comb begin
        for (int unsigned o = 0; o < NumRoutes; o++) begin
            w_req[o] = '0;
            for (int unsigned i = 0; i < NumInputs; i++) begin
                w_req[o][i] = valid_i[i] & route_sel_i[i][o] & ~r_sent[i][o];
            end
        end
    end

    // Per-output arbitration
    always_comb begin
        w_valid = '0;
        for (int unsigned o = 0; o < NumRoutes; o++) begin
            w_winner[o] = '0;
            if (r_lock[o]) begin
                w_winner[o] = r_lock_idx[o];
                w_valid[o]  = w_req[o][r_lock_idx[o]];
            end else begin
                // First requester at or after the pointer, wrapping around
                for (int unsigned k = 0; k < NumInputs; k++) begin
                    if (!w_valid[o] && w_req[o][wrap_add(r_rr_ptr[o], k)]) begin
                        w_valid[o]  = 1'b1;
                        w_winner[o] = wrap_add(r_rr_ptr[o], k);
                    end
                end
            end
        end
    end

    // Output drive and handshake
    always_comb begin
        valid_o = w_valid;
        w_xfer  = w_valid & ready_i;
        for (int unsigned o = 0; o < NumRoutes; o++) begin
            data_o[o]      = '0;
            grant_idx_o[o] = '0;
            if (w_valid[o]) begin
                data_o[o]      = data_i[w_winner[o]];
                grant_idx_o[o] = w_winner[o];
            end
        end
        for (int unsigned i = 0; i < NumInputs; i++) begin
            w_xfer_from[i] = '0;
            for (int unsigned o = 0; o < NumRoutes; o++) begin
                w_xfer_from[i][o] = w_xfer[o] & (w_winner[o] == idx_t'(i));
            end
            // Released when no selected output is still outstanding after this cycle
            w_done[i] = valid_i[i] &
                        ((route_sel_i[i] & ~r_sent[i] & ~w_xfer_from[i]) == '0);
        end
        ready_o = w_done;
    end

    // State update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumInputs; i++) begin
                r_sent[i] <= '0;
            end
            r_lock <= '0;
            for (int unsigned o = 0; o < NumRoutes; o++) begin
                r_lock_idx[o] <= '0;
                r_rr_ptr[o]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumInputs; i++) begin
                if (w_done[i]) r_sent[i] <= '0;
                else           r_sent[i] <= r_sent[i] | w_xfer_from[i];
            end
            for (int unsigned o = 0; o < NumRoutes; o++) begin
                if (w_xfer[o]) begin
                    r_rr_ptr[o] <= wrap_add(w_winner[o], 1);
                    if (LockRouting) begin
                        r_lock[o]     <= ~last_i[w_winner[o]];
                        r_lock_idx[o] <= w_winner[o];
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < NumInputs; gi++) begin : g_chk_in
        assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[gi] && !ready_o[gi]) |=>
                (!valid_i[gi] || ($stable(data_i[gi]) && $stable(route_sel_i[gi]) && $stable(last_i[gi]))))
            else $error("input %0d changed flit while waiting for release", gi);

        assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[gi] && ($countones(route_sel_i[gi]) > 1)) |-> last_i[gi])
            else $error("input %0d multicast flit without last", gi);

        assert property (@(posedge clk_i) disable iff (rst_i)
            !(valid_i[gi] && (route_sel_i[gi] == '0)))
            else $warning("input %0d empty route mask, flit dropped", gi);
    end

    for (genvar go = 0; go < NumRoutes; go++) begin : g_chk_out
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(r_lock[go] && valid_i[r_lock_idx[go]] && !route_sel_i[r_lock_idx[go]][go]))
            else $warning("output %0d locked input presents flit for another output", go);
    end
`endif

endmodule

// File: tb/tb_floo_mcast_output_arbiter.sv
module tb_floo_mcast_output_arbiter;

    localparam int NI = 5;
    localparam int NR = 5;
    typedef logic [7:0] flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0 drives the LockRouting=1 instance, index 1 the LockRouting=0 instance
    logic [1:0][NI-1:0]         valid;
    logic [1:0][NI-1:0]         last;
    logic [1:0][NI-1:0]         ro;
    logic [1:0][NR-1:0]         rdy;
    logic [1:0][NR-1:0]         vo;
    logic [1:0][NI-1:0][NR-1:0] rsel;
    logic [1:0][NI-1:0][7:0]    din;
    logic [1:0][NR-1:0][7:0]    dout;
    logic [1:0][NR-1:0][2:0]    gidx;

    for (genvar gk = 0; gk < 2; gk++) begin : g_dut
        logic [NR-1:0] l_rsel [NI];
        flit_t         l_din  [NI];
        flit_t         l_dout [NR];
        logic [2:0]    l_gidx [NR];
        for (genvar gi = 0; gi < NI; gi++) begin : g_in
            assign l_rsel[gi] = rsel[gk][gi];
            assign l_din[gi]  = din[gk][gi];
        end
        for (genvar go = 0; go < NR; go++) begin : g_out
            assign dout[gk][go] = l_dout[go];
            assign gidx[gk][go] = l_gidx[go];
        end
        floo_mcast_output_arbiter #(
            .NumInputs  (NI),
            .NumRoutes  (NR),
            .flit_t     (flit_t),
            .LockRouting(gk == 0)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .valid_i    (valid[gk]),
            .ready_o    (ro[gk]),
            .data_i     (l_din),
            .route_sel_i(l_rsel),
            .last_i     (last[gk]),
            .valid_o    (vo[gk]),
            .ready_i    (rdy[gk]),
            .data_o     (l_dout),
            .grant_idx_o(l_gidx)
        );
    end

    // Scoreboard entry: full expected output picture for one instance, one cycle
    typedef struct packed {
        logic                 k;
        logic [NR-1:0]        vo;
        logic [NI-1:0]        ro;
        logic [NR-1:0][2:0]   g;
        logic [NR-1:0][7:0]   d;
        logic                 spot;
        logic [NR-1:0]        s_vo;
        logic [NI-1:0]        s_ro;
        logic [2:0]           s_o;
        logic [2:0]           s_g;
        logic [7:0]           s_id;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: which outputs each input has served, who owns each output
    logic [NR-1:0] m_sent [2][NI];
    int            m_own  [2][NR];   // -1 when the output is free
    int            m_ptr  [2][NR];
    logic [1:0][NI-1:0] pred_ro;

    // Hand-computed spot expectations attached to the next issued cycle
    logic       sp_en = 1'b0;
    int         sp_k, sp_o, sp_g, sp_id;
    logic [NR-1:0] sp_vo;
    logic [NI-1:0] sp_ro;

    // Random packet generator state
    int g_left [2][NI];

    task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic bit wants(int k, int i, int o);
        return valid[k][i] && rsel[k][i][o] && !m_sent[k][i][o];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NI; i++) m_sent[k][i] = '0;
            for (int o = 0; o < NR; o++) begin
                m_own[k][o] = -1;
                m_ptr[k][o] = 0;
            end
        end
    endtask

    // Predict this cycle's outputs for both instances, queue them, advance the model
    task automatic issue();
        exp_t e;
        int   win [NR];
        for (int k = 0; k < 2; k++) begin
            e   = '0;
            e.k = (k == 1);
            for (int o = 0; o < NR; o++) begin
                win[o] = -1;
                if (m_own[k][o] >= 0) begin
                    if (wants(k, m_own[k][o], o)) win[o] = m_own[k][o];
                end else begin
                    for (int s = 0; s < NI; s++) begin
                        int c;
                        c = (m_ptr[k][o] + s) % NI;
                        if (win[o] < 0 && wants(k, c, o)) win[o] = c;
                    end
                end
                if (win[o] >= 0) begin
                    e.vo[o] = 1'b1;
                    e.g[o]  = 3'(win[o]);
                    e.d[o]  = din[k][win[o]];
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (valid[k][i]) begin
                    bit ok;
                    ok = 1'b1;
                    for (int o = 0; o < NR; o++) begin
                        if (rsel[k][i][o] && !m_sent[k][i][o] && !(win[o] == i && rdy[k][o])) ok = 1'b0;
                    end
                    e.ro[i] = ok;
                end
            end
            pred_ro[k] = e.ro;
            if (sp_en && sp_k == k) begin
                e.spot = 1'b1;
                e.s_vo = sp_vo;
                e.s_ro = sp_ro;
                e.s_o  = 3'(sp_o);
                e.s_g  = 3'(sp_g);
                e.s_id = 8'(sp_id);
                sp_en  = 1'b0;
            end
            sb.push_back(e);
            if (!rst) begin
                for (int o = 0; o < NR; o++) begin
                    if (win[o] >= 0 && rdy[k][o]) begin
                        m_ptr[k][o] = (win[o] + 1) % NI;
                        if (k == 0) m_own[k][o] = last[k][win[o]] ? -1 : win[o];
                    end
                end
                for (int i = 0; i < NI; i++) begin
                    if (e.ro[i]) m_sent[k][i] = '0;
                    else begin
                        for (int o = 0; o < NR; o++) begin
                            if (win[o] == i && rdy[k][o]) m_sent[k][i][o] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        issue();
        @(posedge clk);
        #1;
    endtask

    task automatic spot(int k, int o, int g, logic [NR-1:0] v, logic [NI-1:0] r, int id);
        sp_en = 1'b1; sp_k = k; sp_o = o; sp_g = g; sp_vo = v; sp_ro = r; sp_id = id;
    endtask

    task automatic set_in(int k, int i, logic v, logic [NR-1:0] r, logic [7:0] d, logic l);
        valid[k][i] = v;
        rsel[k][i]  = r;
        din[k][i]   = d;
        last[k][i]  = l;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        rsel  = '0;
        din   = '0;
        last  = '0;
        rdy   = '1;
        model_reset();
        issue();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_pkt(int k, int i);
        int o1, o2, len;
        o1 = int'($urandom_range(0, NR - 1));
        rsel[k][i] = '0;
        rsel[k][i][o1] = 1'b1;
        if ($urandom_range(0, 9) < 3) begin
            o2 = (o1 + 1 + int'($urandom_range(0, NR - 2))) % NR;
            rsel[k][i][o2] = 1'b1;
            len = 1;
        end else begin
            len = int'($urandom_range(1, 4));
        end
        g_left[k][i] = len;
        din[k][i]    = 8'($urandom);
        last[k][i]   = (len == 1);
        valid[k][i]  = 1'b1;
    endtask

    // Called just after a clock edge: retire accepted flits, start new ones
    task automatic gen_advance();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (valid[k][i] && pred_ro[k][i]) begin
                    g_left[k][i]--;
                    valid[k][i] = 1'b0;
                    if (g_left[k][i] > 0) begin
                        din[k][i]  = 8'($urandom);
                        last[k][i] = (g_left[k][i] == 1);
                    end
                end
                if (!valid[k][i]) begin
                    if (g_left[k][i] > 0) valid[k][i] = ($urandom_range(0, 3) != 0);
                    else if ($urandom_range(0, 2) == 0) start_pkt(k, i);
                end
            end
            for (int o = 0; o < NR; o++) rdy[k][o] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT at the falling edge
    initial begin
        exp_t e;
        int   kk;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e  = sb.pop_front();
                kk = int'(e.k);
                check("valid_o", kk, 64'(vo[kk]), 64'(e.vo));
                check("ready_o", kk, 64'(ro[kk]), 64'(e.ro));
                check("grant_idx_o", kk, 64'(gidx[kk]), 64'(e.g));
                for (int o = 0; o < NR; o++) begin
                    if (e.vo[o]) check($sformatf("data_o[%0d]", o), kk, 64'(dout[kk][o]), 64'(e.d[o]));
                end
                if (e.spot) begin
                    check($sformatf("spot%0d_valid_o", e.s_id), kk, 64'(vo[kk]), 64'(e.s_vo));
                    check($sformatf("spot%0d_ready_o", e.s_id), kk, 64'(ro[kk]), 64'(e.s_ro));
                    check($sformatf("spot%0d_grant", e.s_id), kk, 64'(gidx[kk][e.s_o]), 64'(e.s_g));
                end
            end
        end
    end

    initial begin
        valid = '0; rsel = '0; din = '0; last = '0; rdy = '1;
        for (int k = 0; k < 2; k++) for (int i = 0; i < NI; i++) g_left[k][i] = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Unicast contention: inputs 1 and 3 on output 2 alternate 1,3,1,3,1
        set_in(0, 1, 1'b1, 5'b00100, 8'h10, 1'b1);
        set_in(0, 3, 1'b1, 5'b00100, 8'h30, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c % 2 == 0) spot(0, 2, 1, 5'b00100, 5'b00010, 10 + c);
            else            spot(0, 2, 3, 5'b00100, 5'b01000, 10 + c);
            step();
        end

        // Wormhole lock: 3-flit packet from input 1 holds output 4 against input 2
        do_reset();
        set_in(0, 1, 1'b1, 5'b10000, 8'h11, 1'b0);
        spot(0, 4, 1, 5'b10000, 5'b00010, 20); step();
        set_in(0, 1, 1'b1, 5'b10000, 8'h12, 1'b0);
        set_in(0, 2, 1'b1, 5'b10000, 8'h21, 1'b1);
        spot(0, 4, 1, 5'b10000, 5'b00010, 21); step();
        set_in(0, 1, 1'b1, 5'b10000, 8'h13, 1'b1);
        spot(0, 4, 1, 5'b10000, 5'b00010, 22); step();
        set_in(0, 1, 1'b0, 5'b10000, 8'h13, 1'b1);
        spot(0, 4, 2, 5'b10000, 5'b00100, 23); step();

        // Multicast fork to outputs 0 and 3 with output 3 stalled two cycles
        do_reset();
        set_in(0, 0, 1'b1, 5'b01001, 8'h55, 1'b1);
        rdy[0] = 5'b10111;
        spot(0, 0, 0, 5'b01001, 5'b00000, 30); step();
        spot(0, 3, 0, 5'b01000, 5'b00000, 31); step();
        rdy[0] = 5'b11111;
        spot(0, 3, 0, 5'b01000, 5'b00001, 32); step();
        set_in(0, 0, 1'b1, 5'b01001, 8'h56, 1'b1);
        spot(0, 0, 0, 5'b01001, 5'b00001, 33); step();
        set_in(0, 0, 1'b0, 5'b00000, 8'h00, 1'b0);

        // Empty route mask: released at once, nothing driven
        set_in(0, 2, 1'b1, 5'b00000, 8'h77, 1'b1);
        spot(0, 0, 0, 5'b00000, 5'b00100, 40); step();
        set_in(0, 2, 1'b0, 5'b00000, 8'h00, 1'b0);

        // Reset in the middle of a locked packet
        do_reset();
        set_in(0, 1, 1'b1, 5'b00100, 8'h31, 1'b0);
        spot(0, 2, 1, 5'b00100, 5'b00010, 50); step();
        do_reset();
        set_in(0, 0, 1'b1, 5'b00100, 8'h07, 1'b1);
        set_in(0, 1, 1'b1, 5'b00100, 8'h31, 1'b0);
        spot(0, 2, 0, 5'b00100, 5'b00001, 51); step();

        // No routing lock: two 2-flit packets interleave 0,4,0,4
        do_reset();
        set_in(1, 0, 1'b1, 5'b00010, 8'h01, 1'b0);
        set_in(1, 4, 1'b1, 5'b00010, 8'h41, 1'b0);
        spot(1, 1, 0, 5'b00010, 5'b00001, 60); step();
        set_in(1, 0, 1'b1, 5'b00010, 8'h02, 1'b1);
        spot(1, 1, 4, 5'b00010, 5'b10000, 61); step();
        set_in(1, 4, 1'b1, 5'b00010, 8'h42, 1'b1);
        spot(1, 1, 0, 5'b00010, 5'b00001, 62); step();
        set_in(1, 0, 1'b0, 5'b00010, 8'h02, 1'b1);
        spot(1, 1, 4, 5'b00010, 5'b10000, 63); step();

        // Randomized traffic on both instances against the reference model
        do_reset();
        for (int k = 0; k < 2; k++) for (int i = 0; i < NI; i++) g_left[k][i] = 0;
        gen_advance();
        for (int n = 0; n < 600; n++) begin
            issue();
            @(posedge clk);
            #1;
            gen_advance();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drain", 0, 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/floo_mcast_output_arbiter.md
Name: floo_mcast_output_arbiter

Overview:
- Per-output wormhole arbiter with multicast fork for the ring-on-mesh router.
- Each input port presents a flit plus a multi-hot route mask, as produced by the route-select stage (unicast = one bit set; ring-on-mesh multicast = eject bit plus up/down bit).
- The block shares each output among the inputs using round-robin with wormhole locking.
- Multicast flits are forked to all selected outputs. Each output may accept at a different cycle. The input is released only when every selected output has taken the flit.

Parameters:
- NumInputs, 5, number of requesting input ports (≥2).
- NumRoutes, 5, number of output ports (≥2).
- flit_t, logic, flit payload type; passed through unmodified.
- LockRouting, 1, 1 = hold the output grant from first flit to last flit of a packet; 0 = re-arbitrate every flit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- valid_i  in  NumInputs  flit valid per input.
- ready_o  out  NumInputs  input handshake; the flit is fully delivered.
- data_i  in  NumInputs x flit_t  flit per input.
- route_sel_i  in  NumInputs x NumRoutes  multi-hot destination outputs per input.
- last_i  in  NumInputs  last flit of packet.
- valid_o  out  NumRoutes  flit valid per output.
- ready_i  in  NumRoutes  downstream ready per output.
- data_o  out  NumRoutes x flit_t  flit per output.
- grant_idx_o  out  NumRoutes x $clog2(NumInputs)  winning input per output (0 when valid_o=0).

Behaviour:
- State per input i: sent_q[i][NumRoutes] = outputs that already accepted the current flit.
- State per output o: lock_q[o], lock_idx_q[o], rr_ptr_q[o].
- All state resets to 0 asynchronously on rst_i. Reset mid-packet drops all locks and partial multicast progress. Outputs are combinational, so with valid_i=0 every output is 0.
- Request: req[o][i] = valid_i[i] & route_sel_i[i][o] & ~sent_q[i][o].
- Output grant when lock_q[o]=1: the winner is lock_idx_q[o]. valid_o[o] = req[o][lock_idx_q[o]]. Other inputs are masked.
- Output grant when lock_q[o]=0: round-robin picks the lowest index ≥ rr_ptr_q[o] with a request, wrapping to 0. valid_o[o] = any request.
- data_o[o] = data_i[winner]. valid_o must never depend on ready_i.
- Transfer: xfer[o] = valid_o[o] & ready_i[o].
  - On xfer: rr_ptr_q[o] <= (winner+1) mod NumInputs.
  - If LockRouting: lock_q[o] <= ~last_i[winner] and lock_idx_q[o] <= winner.
- Fork completion: done[i] = valid_i[i] & ((route_sel_i[i] & ~sent_q[i] & ~xfer_from_i) == 0). ready_o[i] = done[i].
  - Zero-latency combinational path ready_i -> ready_o is allowed.
  - If done[i]: sent_q[i] <= 0.
  - Else: sent_q[i] <= sent_q[i] | xfer_from_i.
- Each selected output sees the flit exactly once. Outputs that already accepted are not re-driven while the others stall.
- route_sel_i[i] == 0 with valid_i[i]=1: ready_o[i]=1 in the same cycle. The flit is dropped and a simulation warning is raised.
- Input protocol: data_i, route_sel_i and last_i are held stable while valid_i=1 and ready_o=0. Violation triggers a simulation assertion (non-synthesis).
- Multicast constraint: a flit with popcount(route_sel_i)>1 must have last_i=1 (single-flit multicast). This prevents cross-locking deadlock. Violation triggers an assertion.
- Locked output whose locked input presents valid_i=1 without that output bit set raises a warning. The lock is held until that input's last flit.
- Simultaneous events:
  - One output's xfer and the input's completion in the same cycle clear sent_q; no stale bit remains.
  - Different outputs may serve different inputs in the same cycle.
- Latency: 0 cycles (no buffering). Throughput: 1 flit/cycle per output.

Test Plan:
- Unicast contention: inputs 1 and 3 both request output 2 (route_sel=5'b00100), last=1, ready_i all 1, rr_ptr reset 0 → cycle0 grant_idx_o[2]=1, ready_o=5'b00010; cycle1 grant 3; then alternate 1,3,1.
- Wormhole lock: input 1 sends a 3-flit packet to output 4; input 2 requests output 4 from cycle 1 → output 4 serves input 1 for 3 consecutive flits; input 2 is granted the cycle after input 1's last flit.
- Multicast fork: input 0 route_sel=5'b01001; ready_i[0]=1, ready_i[3]=0 for 2 cycles → output 0 transfers once in cycle 0 and valid_o[0] stays 0 afterwards; ready_o[0] stays 0 until ready_i[3] rises in cycle 2, when valid_o[3] & ready_i[3] and ready_o[0]=1 in the same cycle; sent_q clears.
- Drop case: valid_i[2]=1, route_sel=0 → ready_o[2]=1 immediately, no valid_o asserted, warning logged.
- Reset mid-operation: input 1 locked on output 2 after flit 1 of 4; assert rst_i for 1 cycle → lock cleared; a new request from input 0 to output 2 is granted on the first cycle after reset.
- LockRouting=0: two 2-flit packets from inputs 0 and 4 to output 1 → flits interleave 0,4,0,4.
